pipe_stage_skid: RTL

- Parametrised successor to the fixed instruction/PC pipeline latch: a generic inter-stage pipeline register.
- Adds a valid/ready handshake, a one-entry skid buffer, synchronous flush with configurable zeroing, and a saturating count of flushed entries.
- Sits between any two CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Ready-based back-pressure replaces the per-stage write-enable, so full throughput is kept without a combinational ready path from downstream to upstream.

---
 rtl/pipe_stage_skid.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with a valid/ready handshake and a
// one-entry skid buffer. in_ready depends only on registered state, so no
// combinational path exists from out_ready to in_ready. A synchronous flush
// kills all held beats and a saturating counter records how many were lost.
//
// Handshake: a beat moves across a port on a rising edge where valid and
// ready are both 1. Once out_valid is 1, out_valid and out_data stay
// unchanged until out_ready is seen high. The one exception is flush or
// reset, which withdraws the beat. in_data is ignored while in_valid is 0.
module pipe_stage_skid #(
    parameter int                 DATA_W     = 64,
    parameter logic [DATA_W-1:0]  RESET_DATA = '0,
    parameter bit                 FLUSH_ZERO = 1'b1,
    parameter int                 CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  flush_drops
);

    // The state is encoded directly as {main_valid, skid_valid}.
    // The pattern 2'b01 (skid full, main empty) is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    state_t            state;
    state_t            state_nxt;
    logic              main_valid;
    logic              skid_valid;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              in_xfer;
    logic              out_xfer;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;
    logic [1:0]        drop_add;
    logic [CNT_W:0]    drop_sum;

    assign main_valid = state[1];
    assign skid_valid = state[0];
    assign in_ready   = !skid_valid;
    assign out_valid  = main_valid;
    assign out_data   = main_data;
    assign occupancy  = {1'b0, main_valid} + {1'b0, skid_valid};
    assign in_xfer    = in_valid & in_ready;
    assign out_xfer   = out_valid & out_ready;

    // State register; reset leaves the stage empty and ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and data-register load selects. Flush overrides every transfer.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state_nxt    = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_main_in = 1'b1;
                    end else if (in_xfer) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (out_xfer) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_nxt      = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Payload registers. With FLUSH_ZERO clear, a flush leaves the data in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data <= RESET_DATA;
            skid_data <= RESET_DATA;
        end else if (flush) begin
            if (FLUSH_ZERO) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            if (load_main_in) begin
                main_data <= in_data;
            end else if (load_main_skid) begin
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

    // Beats lost on a flush edge are the held beats, minus one that leaves in
    // the same cycle, plus one accepted in the same cycle. The result is 0..2.
    // An out_xfer can only happen when main_valid is 1, so the subtraction
    // never underflows.
    assign drop_add = occupancy - {1'b0, out_xfer} + {1'b0, in_xfer};
    assign drop_sum = {1'b0, flush_drops} + {{(CNT_W-1){1'b0}}, drop_add};

    // Saturating count of flushed beats. The count never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_drops <= '0;
        end else if (flush) begin
            if (drop_sum > CNT_MAX) begin
                flush_drops <= CNT_MAX[CNT_W-1:0];
            end else begin
                flush_drops <= drop_sum[CNT_W-1:0];
            end
        end
    end

endmodule
